// File: rtl/axi4s_rr_arbiter_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream round-robin arbiter.
// rr_pick works on a fixed 16-bit request vector so one function serves every NUM_SRC.
package axi4s_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int MAX_SRC = 16;

  function automatic int arb_gw(input int numSrc);
    return (numSrc > 1) ? $clog2(numSrc) : 1;
  endfunction

  // First asserted request scanning upward from ptr+1, wrapping modulo numSrc.
  function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [3:0]         ptr,
                                         input int                 numSrc);
    logic [3:0] win;
    logic       found;
    int         idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_SRC; i++) begin
      idx = (int'(ptr) + i) % numSrc;
      if (i <= numSrc && !found && req[idx]) begin
        win   = 4'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axi4s_rr_arbiter_reg_slice.sv
// One-entry AXI4-Stream register slice; a load and a drain may happen in the same cycle.
module axi4s_reg_slice #(
  parameter int DLEN = 32
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            s_tvalid_i,
  output logic            s_tready_o,
  input  logic [DLEN-1:0] s_tdata_i,
  input  logic            s_tlast_i,
  output logic            m_tvalid_o,
  input  logic            m_tready_i,
  output logic [DLEN-1:0] m_tdata_o,
  output logic            m_tlast_o
);

  logic            valid_q;
  logic            last_q;
  logic [DLEN-1:0] data_q;

  assign s_tready_o = !valid_q || m_tready_i;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (s_tvalid_i && s_tready_o) begin
      valid_q <= 1'b1;
      data_q  <= s_tdata_i;
      last_q  <= s_tlast_i;
    end else if (m_tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/axi4s_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream sink among NUM_SRC sources.
// A grant is held from the first beat to the TLAST beat; output goes through a register slice.
module axi4s_rr_arbiter
  import axi4s_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DLEN    = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  output logic [NUM_SRC-1:0]        s_tready,
  input  logic [NUM_SRC*DLEN-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DLEN-1:0]           m_tdata,
  output logic                      m_tlast,
  output logic [$clog2(NUM_SRC)-1:0] o_grant,
  output logic                      o_busy
);

  localparam int GW = arb_gw(NUM_SRC);

  arb_state_t          state_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       ptr_q;
  logic [GW-1:0]       winner;
  logic [MAX_SRC-1:0]  reqExt;
  logic                sliceRdy;
  logic                beatValid;
  logic                beatAccept;
  logic                beatLast;
  logic [DLEN-1:0]     beatData;

  assign reqExt = MAX_SRC'(s_tvalid);
  assign winner = GW'(rr_pick(reqExt, 4'(ptr_q), NUM_SRC));

  assign beatData   = s_tdata[int'(grant_q)*DLEN +: DLEN];
  assign beatLast   = s_tlast[grant_q];
  assign beatValid  = (state_q == BUSY) && s_tvalid[grant_q];
  assign beatAccept = beatValid && sliceRdy;

  // Only the granted source ever sees ready, and never as a function of its own valid.
  always_comb begin
    s_tready = '0;
    if (state_q == BUSY) begin
      s_tready[grant_q] = sliceRdy;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= GW'(NUM_SRC - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|s_tvalid) begin
            grant_q <= winner;
            ptr_q   <= winner;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (beatAccept && beatLast) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = (state_q == BUSY);
  assign o_grant = grant_q;

  axi4s_reg_slice #(
    .DLEN(DLEN)
  ) u_slice (
    .aclk       (aclk),
    .areset     (areset),
    .s_tvalid_i (beatValid),
    .s_tready_o (sliceRdy),
    .s_tdata_i  (beatData),
    .s_tlast_i  (beatLast),
    .m_tvalid_o (m_tvalid),
    .m_tready_i (m_tready),
    .m_tdata_o  (m_tdata),
    .m_tlast_o  (m_tlast)
  );

endmodule

// File: tb/tb_axi4s_rr_arbiter.sv
// Bench for axi4s_rr_arbiter: directed vector table, reset-mid-packet sequence, and
// randomized traffic checked against a packet-level scoreboard with round-robin rules.
module tb_axi4s_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;

  logic             aclk = 1'b0;
  logic             areset;
  logic [NS-1:0]    s_tvalid;
  logic [NS-1:0]    s_tready;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tlast;
  logic [1:0]       o_grant;
  logic             o_busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NS-1:0] sv;
    logic [DW-1:0] d;
    logic          l;
    logic          mr;
    logic          eBusy;
    logic [1:0]    eGrant;
    logic          eMv;
    logic [DW-1:0] eMd;
    logic          eMl;
    logic [NS-1:0] eRdy;
  } vec_t;

  vec_t tbl[13];

  // Reference model state: expected grant holder, last winner and in-flight beats.
  bit         expBusy;
  int         expGrant;
  int         lastWin;
  logic [8:0] sb[$];
  int         remain[NS];
  int         seq[NS];
  bit         haveBeat[NS];

  always #5 aclk = ~aclk;

  axi4s_rr_arbiter #(
    .NUM_SRC(NS),
    .DLEN   (DW)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .o_grant  (o_grant),
    .o_busy   (o_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NS-1:0] sv, input logic [DW-1:0] d, input logic l,
                              input logic mr, input logic eBusy, input logic [1:0] eGrant,
                              input logic eMv, input logic [DW-1:0] eMd, input logic eMl,
                              input logic [NS-1:0] eRdy);
    vec_t v;
    v.sv = sv; v.d = d; v.l = l; v.mr = mr;
    v.eBusy = eBusy; v.eGrant = eGrant; v.eMv = eMv; v.eMd = eMd; v.eMl = eMl; v.eRdy = eRdy;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    s_tvalid = v.sv;
    s_tdata  = {NS{v.d}};
    s_tlast  = {NS{v.l}};
    m_tready = v.mr;
    @(posedge aclk);
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("vec%0d o_busy", i), o_busy, v.eBusy);
    checkOutput($sformatf("vec%0d o_grant", i), o_grant, v.eGrant);
    checkOutput($sformatf("vec%0d m_tvalid", i), m_tvalid, v.eMv);
    checkOutput($sformatf("vec%0d s_tready", i), s_tready, v.eRdy);
    if (v.eMv) begin
      checkOutput($sformatf("vec%0d m_tdata", i), m_tdata, v.eMd);
      checkOutput($sformatf("vec%0d m_tlast", i), m_tlast, v.eMl);
    end
  endtask

  // Each source presents beats {id, seq}; a new packet starts only if its mask bit is set.
  task automatic driveSources(input logic [NS-1:0] mask, input int validPct, input int maxLen);
    logic [1:0] sid;
    logic [5:0] sq;
    for (int s = 0; s < NS; s++) begin
      if (remain[s] == 0 && mask[s] && $urandom_range(99) < validPct)
        remain[s] = $urandom_range(maxLen, 1);
      if (remain[s] > 0 && !haveBeat[s] && $urandom_range(99) < validPct)
        haveBeat[s] = 1'b1;
      sid = 2'(s);
      sq  = 6'(seq[s]);
      s_tvalid[s]          = haveBeat[s];
      s_tdata[s*DW +: DW]  = {sid, sq};
      s_tlast[s]           = (remain[s] == 1);
    end
  endtask

  task automatic stepCycle(input logic [NS-1:0] mask, input int validPct, input int maxLen,
                           input int readyPct);
    logic [NS-1:0] expRdy;
    logic [NS-1:0] acc;
    bit            sliceRdy;
    bit            outAcc;
    bit            arb;
    int            win;
    m_tready = ($urandom_range(99) < readyPct);
    driveSources(mask, validPct, maxLen);
    #2;
    sliceRdy = (sb.size() == 0) || m_tready;
    expRdy = '0;
    if (expBusy && sliceRdy) expRdy[expGrant] = 1'b1;
    checkOutput("rand s_tready", s_tready, expRdy);
    acc    = s_tvalid & expRdy;
    outAcc = (sb.size() != 0) && m_tready;
    arb    = 1'b0;
    win    = 0;
    if (!expBusy && s_tvalid != '0) begin
      arb = 1'b1;
      for (int k = 1; k <= NS; k++) begin
        if (s_tvalid[(lastWin + k) % NS]) begin
          win = (lastWin + k) % NS;
          break;
        end
      end
    end
    @(posedge aclk);
    #1;
    if (outAcc) void'(sb.pop_front());
    for (int s = 0; s < NS; s++) begin
      if (acc[s]) begin
        sb.push_back({s_tlast[s], s_tdata[s*DW +: DW]});
        seq[s]++;
        remain[s]--;
        haveBeat[s] = 1'b0;
        if (remain[s] == 0) expBusy = 1'b0;
      end
    end
    if (arb) begin
      expBusy  = 1'b1;
      expGrant = win;
      lastWin  = win;
    end
    checkOutput("rand o_busy", o_busy, expBusy);
    checkOutput("rand o_grant", o_grant, expGrant);
    checkOutput("rand m_tvalid", m_tvalid, sb.size() != 0);
    if (sb.size() != 0) begin
      checkOutput("rand m_tdata", m_tdata, sb[0][7:0]);
      checkOutput("rand m_tlast", m_tlast, sb[0][8]);
    end
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    #12;
    checkOutput("reset o_busy", o_busy, 1'b0);
    checkOutput("reset o_grant", o_grant, 2'd0);
    checkOutput("reset m_tvalid", m_tvalid, 1'b0);
    checkOutput("reset m_tdata", m_tdata, 8'h00);
    checkOutput("reset m_tlast", m_tlast, 1'b0);
    checkOutput("reset s_tready", s_tready, 4'b0000);
    areset = 1'b0;

    // Source 2 three-beat packet, then source 0 packet with m_tready 1,0,0,1.
    tbl[0]  = mk(4'b0100, 8'h10, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 4'b0100);
    tbl[1]  = mk(4'b0100, 8'h10, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 8'h10, 1'b0, 4'b0100);
    tbl[2]  = mk(4'b0100, 8'h11, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 8'h11, 1'b0, 4'b0100);
    tbl[3]  = mk(4'b0100, 8'h12, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 8'h12, 1'b1, 4'b0000);
    tbl[4]  = mk(4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0, 4'b0000);
    tbl[5]  = mk(4'b0001, 8'hA0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0001);
    tbl[6]  = mk(4'b0001, 8'hA0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA0, 1'b0, 4'b0001);
    tbl[7]  = mk(4'b0001, 8'hA1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA0, 1'b0, 4'b0000);
    tbl[8]  = mk(4'b0001, 8'hA1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 8'hA0, 1'b0, 4'b0000);
    tbl[9]  = mk(4'b0001, 8'hA1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA1, 1'b0, 4'b0001);
    tbl[10] = mk(4'b0001, 8'hA2, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'hA2, 1'b0, 4'b0001);
    tbl[11] = mk(4'b0001, 8'hA3, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'hA3, 1'b1, 4'b0000);
    tbl[12] = mk(4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 4'b0000);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i]);
      checkVector(i, tbl[i]);
    end

    // Reset in the middle of a five-beat packet from source 1.
    s_tvalid = 4'b0010;
    s_tdata  = {NS{8'h51}};
    s_tlast  = '0;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    checkOutput("rstseq grant", o_grant, 2'd1);
    @(posedge aclk); #1;
    s_tdata = {NS{8'h52}};
    @(posedge aclk); #1;
    checkOutput("rstseq m_tdata", m_tdata, 8'h52);
    checkOutput("rstseq m_tvalid", m_tvalid, 1'b1);
    areset = 1'b1;
    #1;
    checkOutput("rstseq async m_tvalid", m_tvalid, 1'b0);
    checkOutput("rstseq async s_tready", s_tready, 4'b0000);
    checkOutput("rstseq async o_busy", o_busy, 1'b0);
    s_tvalid = 4'b1111;
    #2;
    areset = 1'b0;
    @(posedge aclk); #1;
    checkOutput("rstseq first grant", o_grant, 2'd0);
    checkOutput("rstseq first busy", o_busy, 1'b1);
    s_tvalid = '0;
    areset   = 1'b1;
    #2;
    areset   = 1'b0;

    expBusy  = 1'b0;
    expGrant = 0;
    lastWin  = NS - 1;
    sb.delete();
    for (int s = 0; s < NS; s++) begin
      remain[s]   = 0;
      seq[s]      = 0;
      haveBeat[s] = 1'b0;
    end

    for (int c = 0; c < 40; c++)  stepCycle(4'b1111, 100, 1, 100);
    for (int c = 0; c < 600; c++) stepCycle(4'b1111, 70, 4, 60);
    for (int c = 0; c < 40; c++)  stepCycle(4'b0000, 100, 4, 100);
    for (int c = 0; c < 60; c++)  stepCycle(4'b1001, 100, 1, 100);
    for (int c = 0; c < 200; c++) stepCycle(4'b1001, 60, 3, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
